// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretch
// Purpose  : Per-channel event stretcher. Each input edge becomes a HOLD_CYCLES
//            high pulse followed by a GAP_CYCLES low gap. One extra event can
//            be queued per channel; further events are counted as drops.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretch #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 50,
  parameter int GAP_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pulse_in,
  input  logic            enable,
  input  logic            clear_drops,
  output logic [N_CH-1:0] led_out,
  output logic            busy,
  output logic [7:0]      drop_cnt
);

  localparam int c_MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
  localparam int c_DROP_W     = (N_CH > 1) ? $clog2(N_CH + 1) : 1;
  localparam int c_SUM_W      = ((c_DROP_W > 8) ? c_DROP_W : 8) + 1;

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [N_CH-1:0]     r_prev;
  logic [N_CH-1:0]     w_event;
  logic [N_CH-1:0]     w_drops;
  logic [N_CH-1:0]     w_busy_ch;
  logic [c_DROP_W-1:0] w_drop_num;
  logic [7:0]          w_drop_base;
  logic [c_SUM_W-1:0]  w_drop_sum;
  logic [7:0]          w_drop_nxt;
  logic [7:0]          r_drop_cnt;

  // prev tracks the raw input regardless of enable, so a level that is
  // already high when enable rises never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
    end else begin
      r_prev <= pulse_in;
    end
  end

  assign w_event = pulse_in & ~r_prev & {N_CH{enable}};

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_pending;
    logic               w_pending_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_led;
    logic               w_drop;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
        r_cnt     <= '0;
        r_led     <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_pending <= w_pending_nxt;
        r_cnt     <= w_cnt_nxt;
        r_led     <= (w_state_nxt == ST_HOLD);
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_cnt_nxt     = r_cnt;
      w_drop        = 1'b0;

      // While busy, an event either queues or is discarded.
      if (w_event[gi] && (r_state != ST_IDLE)) begin
        if (r_pending) begin
          w_drop = 1'b1;
        end else begin
          w_pending_nxt = 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_event[gi]) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end
        end
        ST_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            w_cnt_nxt = '0;
            // An event landing on this very cycle is served straight away.
            if (r_pending || w_event[gi]) begin
              w_state_nxt   = ST_HOLD;
              w_pending_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b0;
          w_cnt_nxt     = '0;
        end
      endcase
    end

    assign led_out[gi]   = r_led;
    assign w_drops[gi]   = w_drop;
    assign w_busy_ch[gi] = (r_state != ST_IDLE) || r_pending;
  end

  always_comb begin
    w_drop_num = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_drop_num = w_drop_num + c_DROP_W'(w_drops[k]);
    end
  end

  // Clearing restarts the count from this cycle's drops rather than zero.
  assign w_drop_base = clear_drops ? 8'd0 : r_drop_cnt;
  assign w_drop_sum  = c_SUM_W'(w_drop_base) + c_SUM_W'(w_drop_num);
  assign w_drop_nxt  = (w_drop_sum > c_SUM_W'(255)) ? 8'hFF : w_drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else begin
      r_drop_cnt <= w_drop_nxt;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign busy     = |w_busy_ch;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretch
// Purpose  : Self-checking bench for pulse_stretch: vector table, directed
//            corner sequences and random traffic against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

  localparam int N_CH = 4;
  localparam int HOLD = 50;
  localparam int GAP  = 10;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] pulse_in;
  logic            enable;
  logic            clear_drops;
  logic [N_CH-1:0] led_out;
  logic            busy;
  logic [7:0]      drop_cnt;

  int errors = 0;
  int checks = 0;

  pulse_stretch #(
    .N_CH       (N_CH),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .enable     (enable),
    .clear_drops(clear_drops),
    .led_out    (led_out),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a channel remembers the cycle its current HOLD began;
  // its phase is derived from elapsed time since then.
  int              now = 0;
  bit              m_active [N_CH];
  bit              m_pend   [N_CH];
  int              m_start  [N_CH];
  logic [N_CH-1:0] m_prev = '0;
  int              m_dropc = 0;
  logic [N_CH-1:0] m_led = '0;
  logic            m_busy = 1'b0;

  task automatic model_edge(input logic r, input logic en, input logic clr,
                            input logic [N_CH-1:0] p);
    int nd;
    bit ev;
    nd = 0;
    if (r) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        m_active[ch] = 1'b0;
        m_pend[ch]   = 1'b0;
      end
      m_prev  = '0;
      m_dropc = 0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        ev = p[ch] && !m_prev[ch] && en;
        if (!m_active[ch]) begin
          if (ev) begin
            m_active[ch] = 1'b1;
            m_start[ch]  = now + 1;
          end
        end else begin
          if (ev) begin
            if (m_pend[ch]) nd++;
            else m_pend[ch] = 1'b1;
          end
          if (now - m_start[ch] == HOLD + GAP - 1) begin
            if (m_pend[ch]) begin
              m_start[ch] = now + 1;
              m_pend[ch]  = 1'b0;
            end else begin
              m_active[ch] = 1'b0;
            end
          end
        end
      end
      m_prev = p;
      if (clr) m_dropc = 0;
      m_dropc = (m_dropc + nd > 255) ? 255 : m_dropc + nd;
    end
    now++;
    m_busy = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      m_led[ch] = m_active[ch] && ((now - m_start[ch]) < HOLD);
      if (m_active[ch] || m_pend[ch]) m_busy = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic clr,
                      input logic [N_CH-1:0] p);
    rst         = r;
    enable      = en;
    clear_drops = clr;
    pulse_in    = p;
    @(posedge clk);
    model_edge(r, en, clr, p);
    #1;
    chk("model_led", 32'(led_out), 32'(m_led));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_drop", 32'(drop_cnt), 32'(m_dropc));
  endtask

  typedef struct {
    logic            r;
    logic            en;
    logic            clr;
    logic [N_CH-1:0] p;
    int              n;
    logic [N_CH-1:0] led;
    logic            bsy;
    logic [7:0]      drop;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic en, input logic clr,
                              input logic [N_CH-1:0] p, input int n,
                              input logic [N_CH-1:0] led, input logic bsy,
                              input logic [7:0] drop);
    vec_t v;
    v.r = r; v.en = en; v.clr = clr; v.p = p; v.n = n;
    v.led = led; v.bsy = bsy; v.drop = drop;
    return v;
  endfunction

  vec_t tbl[$];
  int   guard;

  initial begin
    rst = 1'b1; enable = 1'b0; clear_drops = 1'b0; pulse_in = '0;

    // Single pulse on ch0, held level on ch1, three pulses on ch2, enable gating.
    tbl.push_back(mk(1, 1, 0, 4'b0000,   2, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0001,   1, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  49, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   1, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   9, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0010,  10, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0010, 190, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0100,   1, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   4, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0100,   1, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  14, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0100,   1, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  30, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  10, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  49, 4'b0100, 1, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   1, 4'b0000, 1, 1));
    tbl.push_back(mk(0, 1, 0, 4'b0000,  10, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 1, 1, 4'b0000,   1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1111,   1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000,   1, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1111,   3, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b1111,   2, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b0000,   1, 4'b0000, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].n) step(tbl[i].r, tbl[i].en, tbl[i].clr, tbl[i].p);
      chk($sformatf("tbl%0d_led", i), 32'(led_out), 32'(tbl[i].led));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].drop));
    end

    // Event on the last GAP cycle re-enters HOLD with no IDLE cycle.
    step(1, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0001);
    repeat (59) step(0, 1, 0, 4'b0000);
    chk("lastgap_low", 32'(led_out), 32'h0);
    chk("lastgap_busy", 32'(busy), 32'h1);
    step(0, 1, 0, 4'b0001);
    chk("lastgap_rehold", 32'(led_out), 32'h1);
    chk("lastgap_rehold_busy", 32'(busy), 32'h1);
    repeat (49) step(0, 1, 0, 4'b0000);
    chk("lastgap_hold_end", 32'(led_out), 32'h1);
    repeat (11) step(0, 1, 0, 4'b0000);
    chk("lastgap_idle", 32'(busy), 32'h0);

    // Four simultaneous drops, then clear with one drop in the same cycle.
    step(1, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b1111);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b1111);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b1111);
    chk("drop4", 32'(drop_cnt), 32'd4);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 1, 4'b0001);
    chk("clear_drop1", 32'(drop_cnt), 32'd1);

    // Saturation: climb to 254 then add a multi-channel drop.
    guard = 0;
    while (m_dropc < 253 && guard < 1000) begin
      step(0, 1, 0, 4'b0000);
      step(0, 1, 0, 4'b1111);
      guard++;
    end
    guard = 0;
    while (m_dropc < 254 && guard < 200) begin
      step(0, 1, 0, 4'b0000);
      step(0, 1, 0, 4'b0001);
      guard++;
    end
    chk("sat_254", 32'(drop_cnt), 32'd254);
    guard = 0;
    while (m_dropc < 255 && guard < 200) begin
      step(0, 1, 0, 4'b0000);
      step(0, 1, 0, 4'b1111);
      guard++;
    end
    chk("sat_255", 32'(drop_cnt), 32'd255);
    repeat (20) begin
      step(0, 1, 0, 4'b0000);
      step(0, 1, 0, 4'b1111);
    end
    chk("sat_hold", 32'(drop_cnt), 32'd255);

    // enable dropped mid-HOLD: the queued pulse is still emitted.
    step(1, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0001);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0001);
    repeat (58) step(0, 0, 0, 4'($urandom_range(0, 15)));
    chk("en0_pending_emit", 32'(led_out), 32'h1);
    chk("en0_no_drops", 32'(drop_cnt), 32'd0);
    repeat (60) step(0, 0, 0, 4'b0000);
    chk("en0_idle", 32'(busy), 32'h0);

    // Reset mid-HOLD with a pending event abandons everything.
    step(1, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0001);
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0001);
    repeat (17) step(0, 1, 0, 4'b0000);
    chk("pre_rst_led", 32'(led_out), 32'h1);
    step(1, 1, 0, 4'b0000);
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (100) step(0, 1, 0, 4'b0000);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_led", 32'(led_out), 32'h0);

    // A level held across reset release counts as a fresh event.
    step(1, 1, 0, 4'b0001);
    step(1, 1, 0, 4'b0001);
    chk("rst_hold_led", 32'(led_out), 32'h0);
    step(0, 1, 0, 4'b0001);
    chk("rst_release_event", 32'(led_out), 32'h1);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      logic [N_CH-1:0] p;
      for (int b = 0; b < N_CH; b++) p[b] = ($urandom_range(0, 9) < 2);
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 199) == 0), p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
